// File: rtl/tdc_pkg.sv
// Shared defaults and FSM encoding for the TDC hit decoder.
package tdc_pkg;

  localparam int TAPS_DEF     = 64;
  localparam int COARSE_W_DEF = 24;
  localparam int FINE_W_DEF   = $clog2(TAPS_DEF + 1);
  localparam int DEPTH_DEF    = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_HOLD  = 2'd2
  } tdc_state_e;

endpackage

// File: rtl/tdc_ts_fifo.sv
// Synchronous timestamp FIFO; a push while full is accepted only alongside a pop.
module tdc_ts_fifo #(
  parameter int W     = 31,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         clrn,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0][W-1:0] mem;
  logic [AW:0]             wr_ptr, rd_ptr;
  logic                    do_wr, do_rd;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_rd = pop & ~empty;
  assign do_wr = push & (~full | do_rd);

  // Gated so the output reads zero after reset without clearing the storage.
  assign rdata = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/tdc_hit_decoder.sv
// Carry-chain TDC hit decoder: S1 sample, S2 popcount + arming FSM, S3 FIFO write.
module tdc_hit_decoder
  import tdc_pkg::*;
#(
  parameter int TAPS     = TAPS_DEF,
  parameter int COARSE_W = COARSE_W_DEF,
  parameter int FINE_W   = $clog2(TAPS + 1),
  parameter int DEPTH    = DEPTH_DEF
) (
  input  logic                       clk,
  input  logic                       clrn,
  input  logic                       en,
  input  logic [TAPS-1:0]            taps,
  output logic                       ts_valid,
  input  logic                       ts_ready,
  output logic [COARSE_W+FINE_W-1:0] ts_data,
  output logic [7:0]                 drop_cnt
);

  localparam int TS_W = COARSE_W + FINE_W;

  logic [COARSE_W-1:0] coarse, coarse_s1;
  logic [TAPS-1:0]     taps_s1;
  logic                s1_vld;
  logic [FINE_W-1:0]   fine_s2;
  tdc_state_e          state;
  logic                wr_req;
  logic [TS_W-1:0]     wr_data;
  logic                fifo_full, fifo_empty, pop, drop;

  // S1: tap sample and coarse time of the same edge
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      coarse    <= '0;
      coarse_s1 <= '0;
      taps_s1   <= '0;
      s1_vld    <= 1'b0;
    end else begin
      coarse    <= coarse + 1'b1;
      coarse_s1 <= coarse;
      taps_s1   <= taps;
      s1_vld    <= 1'b1;
    end
  end

  // S2: popcount tolerates bubbles in the thermometer code
  always_comb begin
    fine_s2 = '0;
    for (int i = 0; i < TAPS; i++) fine_s2 = fine_s2 + FINE_W'(taps_s1[i]);
  end

  // s1_vld keeps the reset-cleared S1 register from posing as a quiet chain,
  // so arming after reset needs a real all-zero sample.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state   <= ST_IDLE;
      wr_req  <= 1'b0;
      wr_data <= '0;
    end else begin
      wr_req <= 1'b0;
      if (!en) begin
        state <= ST_IDLE;
      end else if (s1_vld) begin
        case (state)
          ST_IDLE:  if (fine_s2 == '0) state <= ST_ARMED;
          ST_ARMED: if (fine_s2 != '0) begin
            wr_req  <= 1'b1;
            wr_data <= {coarse_s1, fine_s2};
            state   <= ST_HOLD;
          end
          ST_HOLD:  if (fine_s2 == '0) state <= ST_ARMED;
          default:  state <= ST_IDLE;
        endcase
      end
    end
  end

  // S3: buffer write, or count the loss when full with no pop in the same cycle
  assign pop  = ts_valid & ts_ready;
  assign drop = wr_req & fifo_full & ~pop;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn)                          drop_cnt <= '0;
    else if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
  end

  tdc_ts_fifo #(
    .W     (TS_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .clrn  (clrn),
    .push  (wr_req),
    .wdata (wr_data),
    .pop   (pop),
    .rdata (ts_data),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign ts_valid = ~fifo_empty;

endmodule

// File: tb/tb_tdc_hit_decoder.sv
// Directed bench for tdc_hit_decoder; coarse width reduced so the wrap case fits in a short run.
module tb_tdc_hit_decoder;

  localparam int TAPS = 64;
  localparam int CW   = 10;
  localparam int FW   = 7;
  localparam int TW   = CW + FW;

  logic            clk = 1'b0;
  logic            clrn, en, ts_ready, ts_valid;
  logic [TAPS-1:0] taps;
  logic [TW-1:0]   ts_data;
  logic [7:0]      drop_cnt;

  int total = 0;
  int bad   = 0;

  logic [CW-1:0] mc;
  logic [TW-1:0] got[$];
  logic [TW-1:0] exp_q[$];

  tdc_hit_decoder #(
    .TAPS(TAPS), .COARSE_W(CW), .FINE_W(FW), .DEPTH(4)
  ) dut (
    .clk(clk), .clrn(clrn), .en(en), .taps(taps),
    .ts_valid(ts_valid), .ts_ready(ts_ready), .ts_data(ts_data), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  // reference coarse counter
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) mc <= '0;
    else       mc <= mc + 1'b1;
  end

  // record every handshake, sampled once inputs for the coming edge are settled
  always @(negedge clk) begin
    #2;
    if (clrn && ts_valid && ts_ready) got.push_back(ts_data);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    if (obs !== expv) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_mc(input logic [CW-1:0] v);
    for (int i = 0; i < 3000 && mc != v; i++) tick();
    chk("wait_mc", 32'(mc), 32'(v));
  endtask

  task automatic hit(input logic [TAPS-1:0] v, input logic [FW-1:0] f);
    taps = v;
    exp_q.push_back({mc, f});
    tick();
    taps = '0;
    tick_n(4);
  endtask

  task automatic drain_chk(input string tag);
    chk({tag, "_n"}, 32'(got.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      chk(tag, (i < got.size()) ? 32'(got[i]) : 32'hDEAD_BEEF, 32'(exp_q[i]));
    got.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [TAPS-1:0] v;
    clrn = 1'b0; en = 1'b1; ts_ready = 1'b1; taps = '0;
    #3;
    chk("rst_valid", 32'(ts_valid), 0);
    chk("rst_data",  32'(ts_data),  0);
    chk("rst_drop",  32'(drop_cnt), 0);
    tick_n(3);
    clrn = 1'b1;

    // latency: hit at coarse 100 -> valid at 103 with {100,16}
    wait_mc(10'd100);
    taps = 64'h0000_0000_0000_FFFF;
    tick(); taps = '0;
    chk("lat_t1", 32'(ts_valid), 0);
    tick();
    chk("lat_t2", 32'(ts_valid), 0);
    tick();
    chk("lat_t3", 32'(ts_valid), 1);
    chk("lat_data", 32'(ts_data), 32'({10'd100, 7'd16}));
    tick_n(3);
    got.delete();

    // bubble-tolerant popcount and full-scale code
    hit(64'h0000_0000_000F_0FFF, 7'd16);
    hit({TAPS{1'b1}}, 7'd64);
    tick_n(3);
    drain_chk("bubble");

    // a held hit yields one timestamp; re-arm needs a quiet sample
    taps = 64'h0000_0000_0000_FFFF;
    exp_q.push_back({mc, 7'd16});
    tick_n(10);
    taps = '0;
    tick_n(4);
    hit(64'h0000_0000_0000_00FF, 7'd8);
    tick_n(3);
    drain_chk("hold");

    // buffer overflow with consumer stalled
    ts_ready = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      v = '1;
      v = v >> (TAPS - k);
      hit(v, FW'(k));
    end
    void'(exp_q.pop_back());
    void'(exp_q.pop_back());
    tick_n(2);
    chk("drop_cnt", 32'(drop_cnt), 2);
    chk("full_valid", 32'(ts_valid), 1);
    chk("stall_data", 32'(ts_data), 32'(exp_q[0]));
    tick_n(3);
    chk("stall_hold", 32'(ts_data), 32'(exp_q[0]));
    ts_ready = 1'b1;
    tick_n(8);
    drain_chk("drain");

    // disarmed block ignores hits
    en = 1'b0;
    tick_n(2);
    hit(64'h0000_0000_0000_FFFF, 7'd16);
    void'(exp_q.pop_back());
    en = 1'b1;
    tick_n(4);
    chk("en_off", 32'(got.size()), 0);

    // coarse wrap
    wait_mc(10'h3FF);
    taps = '1;
    exp_q.push_back({mc, 7'd64});
    tick(); taps = '0;
    tick();
    taps = 64'h0000_0000_0000_FFFF;
    exp_q.push_back({mc, 7'd16});
    tick(); taps = '0;
    tick_n(6);
    drain_chk("wrap");

    // reset while entries are buffered
    ts_ready = 1'b0;
    for (int k = 0; k < 6; k++) hit(64'h0000_0000_0000_0003, 7'd2);
    exp_q.delete();
    chk("pre_rst_drop", 32'(drop_cnt), 4);
    chk("pre_rst_valid", 32'(ts_valid), 1);
    clrn = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(ts_valid), 0);
    chk("mid_rst_drop",  32'(drop_cnt), 0);
    chk("mid_rst_data",  32'(ts_data),  0);
    tick_n(2);
    taps = 64'h0000_0000_0000_FFFF;
    clrn = 1'b1;
    tick_n(5);
    ts_ready = 1'b1;
    tick_n(3);
    chk("rst_nocap", 32'(got.size()), 0);
    taps = '0;
    tick_n(3);
    hit(64'h0000_0000_0000_FFFF, 7'd16);
    tick_n(3);
    drain_chk("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
